// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the 6502 core: steps through fetch, operand,
// pointer, fix-up, memory and read-modify-write cycles using a ready/wait handshake.
module cpu_ctrl_seq #(
  parameter int unsigned PAGE_PENALTY = 1,
  parameter int unsigned RMW_EN       = 1,
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned CYC_W        = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [3:0]       addr_mode_i,
  input  logic             is_store_i,
  input  logic             is_rmw_i,
  input  logic             page_cross_i,
  input  logic             halt_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [2:0]       addr_sel_o,
  output logic             pc_inc_o,
  output logic             ir_load_o,
  output logic             instr_done_o,
  output logic             bus_err_o,
  output logic [CYC_W-1:0] cyc_cnt_o,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_OP1    = 4'd1,
    S_OP2    = 4'd2,
    S_PTR_LO = 4'd3,
    S_PTR_HI = 4'd4,
    S_FIX    = 4'd5,
    S_MEM    = 4'd6,
    S_MODIFY = 4'd7,
    S_WRITE  = 4'd8
  } state_e;

  localparam logic [3:0] M_IMPL = 4'd0;
  localparam logic [3:0] M_IMM  = 4'd1;
  localparam logic [3:0] M_ZP   = 4'd2;
  localparam logic [3:0] M_ZPX  = 4'd3;
  localparam logic [3:0] M_ZPY  = 4'd4;
  localparam logic [3:0] M_ABS  = 4'd5;
  localparam logic [3:0] M_ABSX = 4'd6;
  localparam logic [3:0] M_ABSY = 4'd7;
  localparam logic [3:0] M_INDX = 4'd8;
  localparam logic [3:0] M_INDY = 4'd9;

  localparam logic [2:0] SEL_PC  = 3'd0;
  localparam logic [2:0] SEL_ZP  = 3'd1;
  localparam logic [2:0] SEL_PTR = 3'd2;
  localparam logic [2:0] SEL_EA  = 3'd3;

  localparam int unsigned       WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_e             state_q, state_d, nxt;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CYC_W-1:0]   run_q, run_d, run_inc;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               halted, hs, retire, timeout, zp_mode, we_raw;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      run_q   <= '0;
      cyc_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    state_d    = state_q;
    wait_d     = wait_q;
    run_d      = run_q;
    cyc_d      = cyc_q;
    nxt        = state_q;
    addr_sel_o = SEL_PC;
    we_raw     = 1'b0;
    pc_inc_o   = 1'b0;
    ir_load_o  = 1'b0;

    halted    = (state_q == S_FETCH) && halt_i;
    mem_req_o = !rst_i && !halted;
    hs        = mem_req_o && mem_ready_i;
    zp_mode   = addr_mode_i inside {M_ZP, M_ZPX, M_ZPY};

    case (state_q)
      S_FETCH: begin
        nxt       = S_OP1;
        ir_load_o = hs;
        pc_inc_o  = hs;
      end
      S_OP1: begin
        // Implied (and undefined) modes do a dummy read without advancing the PC.
        pc_inc_o = hs && (addr_mode_i inside {[M_IMM:M_INDY]});
        case (addr_mode_i)
          M_ZP, M_ZPX, M_ZPY:    nxt = S_MEM;
          M_ABS, M_ABSX, M_ABSY: nxt = S_OP2;
          M_INDX, M_INDY:        nxt = S_PTR_LO;
          default:               nxt = S_FETCH;
        endcase
      end
      S_OP2: begin
        pc_inc_o = hs;
        nxt = ((PAGE_PENALTY != 0) && page_cross_i &&
               (addr_mode_i inside {M_ABSX, M_ABSY})) ? S_FIX : S_MEM;
      end
      S_PTR_LO: begin
        addr_sel_o = SEL_PTR;
        nxt        = S_PTR_HI;
      end
      S_PTR_HI: begin
        addr_sel_o = SEL_PTR;
        nxt = ((PAGE_PENALTY != 0) && page_cross_i && (addr_mode_i == M_INDY)) ? S_FIX : S_MEM;
      end
      S_FIX: begin
        addr_sel_o = SEL_EA;
        nxt        = S_MEM;
      end
      S_MEM: begin
        addr_sel_o = zp_mode ? SEL_ZP : SEL_EA;
        we_raw     = is_store_i && !(is_rmw_i && (RMW_EN != 0));
        nxt        = ((RMW_EN != 0) && is_rmw_i) ? S_MODIFY : S_FETCH;
      end
      S_MODIFY: begin
        addr_sel_o = SEL_EA;
        we_raw     = 1'b1;
        nxt        = S_WRITE;
      end
      S_WRITE: begin
        addr_sel_o = SEL_EA;
        we_raw     = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase

    mem_we_o     = we_raw && mem_req_o;
    retire       = hs && (state_q != S_FETCH) && (nxt == S_FETCH);
    timeout      = (MAX_WAIT != 0) && mem_req_o && !mem_ready_i && (wait_q == WAIT_MAX);
    instr_done_o = retire;
    bus_err_o    = timeout;
    run_inc      = (run_q == '1) ? run_q : run_q + CYC_W'(1);

    if (hs) begin
      state_d = nxt;
      wait_d  = '0;
    end else if (timeout) begin
      state_d = S_FETCH;
      wait_d  = '0;
    end else if (mem_req_o && (MAX_WAIT != 0)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // The running count includes the retiring cycle itself, hence run_inc on retire.
    if (halted || timeout) begin
      run_d = '0;
    end else if (retire) begin
      cyc_d = run_inc;
      run_d = '0;
    end else begin
      run_d = run_inc;
    end
  end

  assign cyc_cnt_o = cyc_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: default instance plus a PAGE_PENALTY=0/RMW_EN=0
// instance sharing the same stimulus.
module tb_cpu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_i, is_store_i, is_rmw_i, page_cross_i, halt_i, mem_ready_i;
  logic [3:0] addr_mode_i;
  logic       mem_req_o, mem_we_o, pc_inc_o, ir_load_o, instr_done_o, bus_err_o;
  logic [2:0] addr_sel_o;
  logic [3:0] cyc_cnt_o, state_o;
  logic       a_mem_req_o, a_mem_we_o, a_pc_inc_o, a_ir_load_o, a_instr_done_o, a_bus_err_o;
  logic [2:0] a_addr_sel_o;
  logic [3:0] a_cyc_cnt_o, a_state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_ctrl_seq dut (
    .clk_i(clk), .rst_i(rst_i), .addr_mode_i(addr_mode_i), .is_store_i(is_store_i),
    .is_rmw_i(is_rmw_i), .page_cross_i(page_cross_i), .halt_i(halt_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .addr_sel_o(addr_sel_o), .pc_inc_o(pc_inc_o), .ir_load_o(ir_load_o),
    .instr_done_o(instr_done_o), .bus_err_o(bus_err_o), .cyc_cnt_o(cyc_cnt_o),
    .state_o(state_o)
  );

  cpu_ctrl_seq #(.PAGE_PENALTY(0), .RMW_EN(0)) dut_alt (
    .clk_i(clk), .rst_i(rst_i), .addr_mode_i(addr_mode_i), .is_store_i(is_store_i),
    .is_rmw_i(is_rmw_i), .page_cross_i(page_cross_i), .halt_i(halt_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(a_mem_req_o), .mem_we_o(a_mem_we_o),
    .addr_sel_o(a_addr_sel_o), .pc_inc_o(a_pc_inc_o), .ir_load_o(a_ir_load_o),
    .instr_done_o(a_instr_done_o), .bus_err_o(a_bus_err_o), .cyc_cnt_o(a_cyc_cnt_o),
    .state_o(a_state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; halt_i = 1'b0; mem_ready_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; halt_i = 1'b0; mem_ready_i = 1'b1; addr_mode_i = 4'd1;
    is_store_i = 1'b1; is_rmw_i = 1'b0; page_cross_i = 1'b0;
    tick(); tick();
    checks++;
    if (state_o !== 4'd0 || cyc_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_state state=%0d cyc=%0d expected state=0 cyc=0", state_o, cyc_cnt_o);
    end
    checks++;
    if ({mem_req_o, mem_we_o, instr_done_o, bus_err_o, ir_load_o, pc_inc_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs req=%b we=%b done=%b err=%b ir=%b pc=%b expected all 0",
               mem_req_o, mem_we_o, instr_done_o, bus_err_o, ir_load_o, pc_inc_o);
    end
    rst_i = 1'b0; is_store_i = 1'b0;
  endtask

  task automatic test_imm();
    int pc_cnt = 0;
    int exp_st[2] = '{0, 1};
    addr_mode_i = 4'd1;
    for (int i = 0; i < 2; i++) begin
      #1;
      pc_cnt += int'(pc_inc_o);
      checks++;
      if (state_o !== 4'(exp_st[i]) || instr_done_o !== (i == 1) || addr_sel_o !== 3'd0) begin
        failures++;
        $display("FAIL imm_cycle%0d state=%0d done=%b sel=%0d expected state=%0d done=%b sel=0",
                 i, state_o, instr_done_o, addr_sel_o, exp_st[i], (i == 1));
      end
      tick();
    end
    checks++;
    if (state_o !== 4'd0 || cyc_cnt_o !== 4'd2 || pc_cnt != 2) begin
      failures++;
      $display("FAIL imm_result state=%0d cyc=%0d pc_inc=%0d expected 0/2/2", state_o, cyc_cnt_o, pc_cnt);
    end
  endtask

  task automatic test_page_cross();
    int exp_st[5] = '{0, 1, 2, 5, 6};
    do_reset();
    addr_mode_i = 4'd6; page_cross_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(exp_st[i]) || instr_done_o !== (i == 4)) begin
        failures++;
        $display("FAIL absx_cycle%0d state=%0d done=%b expected state=%0d done=%b",
                 i, state_o, instr_done_o, exp_st[i], (i == 4));
      end
      if (i == 3) begin
        checks++;
        if (a_state_o !== 4'd6) begin
          failures++;
          $display("FAIL absx_nopenalty_state state=%0d expected 6", a_state_o);
        end
      end
      tick();
    end
    checks++;
    if (cyc_cnt_o !== 4'd5 || a_cyc_cnt_o !== 4'd4) begin
      failures++;
      $display("FAIL absx_cycles cyc=%0d alt_cyc=%0d expected 5 and 4", cyc_cnt_o, a_cyc_cnt_o);
    end
    page_cross_i = 1'b0;
  endtask

  task automatic test_ind_y_store();
    int exp_st[5]  = '{0, 1, 3, 4, 6};
    int exp_sel[5] = '{0, 0, 2, 2, 3};
    do_reset();
    addr_mode_i = 4'd9; is_store_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(exp_st[i]) || addr_sel_o !== 3'(exp_sel[i]) || mem_we_o !== (i == 4)) begin
        failures++;
        $display("FAIL indy_cycle%0d state=%0d sel=%0d we=%b expected state=%0d sel=%0d we=%b",
                 i, state_o, addr_sel_o, mem_we_o, exp_st[i], exp_sel[i], (i == 4));
      end
      tick();
    end
    checks++;
    if (cyc_cnt_o !== 4'd5) begin
      failures++;
      $display("FAIL indy_cycles cyc=%0d expected 5", cyc_cnt_o);
    end
    is_store_i = 1'b0;
  endtask

  task automatic test_rmw();
    int exp_st[5]  = '{0, 1, 6, 7, 8};
    int exp_sel[5] = '{0, 0, 1, 3, 3};
    logic [4:0] exp_we = 5'b11000;
    do_reset();
    addr_mode_i = 4'd2; is_store_i = 1'b1; is_rmw_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(exp_st[i]) || addr_sel_o !== 3'(exp_sel[i]) || mem_we_o !== exp_we[i]) begin
        failures++;
        $display("FAIL rmw_cycle%0d state=%0d sel=%0d we=%b expected state=%0d sel=%0d we=%b",
                 i, state_o, addr_sel_o, mem_we_o, exp_st[i], exp_sel[i], exp_we[i]);
      end
      tick();
    end
    checks++;
    if (cyc_cnt_o !== 4'd5 || a_cyc_cnt_o !== 4'd3) begin
      failures++;
      $display("FAIL rmw_cycles cyc=%0d alt_cyc=%0d expected 5 and 3", cyc_cnt_o, a_cyc_cnt_o);
    end
    is_store_i = 1'b0; is_rmw_i = 1'b0;
  endtask

  task automatic test_wait_states();
    int exp_st[7]   = '{0, 1, 2, 2, 2, 2, 6};
    logic [6:0] rdy = 7'b1100011;
    logic [6:0] pci = 7'b0100011;
    do_reset();
    addr_mode_i = 4'd5;
    for (int i = 0; i < 7; i++) begin
      mem_ready_i = rdy[i];
      #1;
      checks++;
      if (state_o !== 4'(exp_st[i]) || pc_inc_o !== pci[i] || mem_req_o !== 1'b1) begin
        failures++;
        $display("FAIL wait_cycle%0d state=%0d pc_inc=%b req=%b expected state=%0d pc_inc=%b req=1",
                 i, state_o, pc_inc_o, mem_req_o, exp_st[i], pci[i]);
      end
      tick();
    end
    checks++;
    if (cyc_cnt_o !== 4'd7) begin
      failures++;
      $display("FAIL wait_cycles cyc=%0d expected 7", cyc_cnt_o);
    end
    mem_ready_i = 1'b1;
  endtask

  task automatic test_wait_limit();
    int errs = 0;
    addr_mode_i = 4'd5; mem_ready_i = 1'b1;
    tick(); tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      errs += int'(bus_err_o);
      tick();
    end
    mem_ready_i = 1'b1;
    #1;
    errs += int'(bus_err_o);
    tick();
    checks++;
    if (errs != 0 || state_o !== 4'd6) begin
      failures++;
      $display("FAIL wait_limit_hs errors=%0d state=%0d expected 0 errors state=6", errs, state_o);
    end
    tick();
    checks++;
    if (cyc_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL cyc_saturate cyc=%0d expected 15", cyc_cnt_o);
    end
  endtask

  task automatic test_timeout();
    int dones = 0;
    addr_mode_i = 4'd5; mem_ready_i = 1'b1;
    tick(); tick();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      dones += int'(instr_done_o);
      checks++;
      if (bus_err_o !== (i == 15)) begin
        failures++;
        $display("FAIL timeout_err_wait%0d err=%b expected %b", i, bus_err_o, (i == 15));
      end
      tick();
    end
    checks++;
    if (state_o !== 4'd0 || dones != 0 || cyc_cnt_o !== 4'd15) begin
      failures++;
      $display("FAIL timeout_abort state=%0d dones=%0d cyc=%0d expected 0/0/15", state_o, dones, cyc_cnt_o);
    end
    mem_ready_i = 1'b1; addr_mode_i = 4'd1;
    tick(); tick();
    checks++;
    if (cyc_cnt_o !== 4'd2) begin
      failures++;
      $display("FAIL timeout_recover cyc=%0d expected 2", cyc_cnt_o);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    addr_mode_i = 4'd1; halt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (mem_req_o !== 1'b0 || ir_load_o !== 1'b0 || state_o !== 4'd0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL halt_hold bad_cycles=%0d expected 0", bad);
    end
    halt_i = 1'b0;
    #1;
    checks++;
    if (ir_load_o !== 1'b1 || mem_req_o !== 1'b1) begin
      failures++;
      $display("FAIL halt_release ir_load=%b req=%b expected 1/1", ir_load_o, mem_req_o);
    end
    tick();
    halt_i = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd1 || instr_done_o !== 1'b1) begin
      failures++;
      $display("FAIL halt_midinstr state=%0d done=%b expected 1/1", state_o, instr_done_o);
    end
    tick();
    checks++;
    if (state_o !== 4'd0 || mem_req_o !== 1'b0 || cyc_cnt_o !== 4'd2) begin
      failures++;
      $display("FAIL halt_boundary state=%0d req=%b cyc=%0d expected 0/0/2", state_o, mem_req_o, cyc_cnt_o);
    end
    halt_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    addr_mode_i = 4'd2; mem_ready_i = 1'b1;
    tick(); tick();
    rst_i = 1'b1;
    #1;
    checks++;
    if (state_o !== 4'd6 || mem_req_o !== 1'b0 || instr_done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_during state=%0d req=%b done=%b expected 6/0/0", state_o, mem_req_o, instr_done_o);
    end
    tick();
    rst_i = 1'b0;
    checks++;
    if (state_o !== 4'd0 || cyc_cnt_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_after state=%0d cyc=%0d expected 0/0", state_o, cyc_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_page_cross();
    test_ind_y_store();
    test_rmw();
    test_wait_states();
    test_wait_limit();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
Name: cpu_ctrl_seq

Overview:
- Parametrised multi-cycle control sequencer for the NES 6502 core. It replaces the fixed fetch/operand/execute FSM.
- Covers all 6502 addressing modes, a ready-based memory handshake with wait states and timeout, optional page-cross penalty cycle, read-modify-write (RMW) write-back, and halt.
- Drives memory address-source select, PC increment and instruction-register load; reports per-instruction cycle count.

Parameters:
- PAGE_PENALTY, 1, 1 = insert FIX cycle on page cross for ABS_X/ABS_Y/IND_Y; 0 = never.
- RMW_EN, 1, 1 = RMW instructions take MODIFY+WRITE cycles; 0 = treated as plain read.
- MAX_WAIT, 15, max consecutive wait cycles per bus access before timeout; 0 = no timeout.
- CYC_W, 4, width of cyc_cnt_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- addr_mode_i  in  4  0 IMPLIED, 1 IMMEDIATE, 2 ZP, 3 ZP_X, 4 ZP_Y, 5 ABS, 6 ABS_X, 7 ABS_Y, 8 IND_X, 9 IND_Y; others treated as IMPLIED; valid in all states except FETCH
- is_store_i  in  1  instruction writes memory
- is_rmw_i  in  1  instruction is read-modify-write
- page_cross_i  in  1  effective-address add crossed a page (valid in OP2/PTR_HI)
- halt_i  in  1  stop at next instruction boundary
- mem_ready_i  in  1  memory completes current access this cycle
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  write access
- addr_sel_o  out  3  0 PC, 1 ZP operand, 2 pointer, 3 effective address
- pc_inc_o  out  1  increment PC this cycle
- ir_load_o  out  1  latch opcode this cycle
- instr_done_o  out  1  one-cycle pulse, instruction retired
- bus_err_o  out  1  one-cycle pulse, access timed out
- cyc_cnt_o  out  CYC_W  cycles of the last retired instruction, saturating
- state_o  out  4  current state: 0 FETCH, 1 OP1, 2 OP2, 3 PTR_LO, 4 PTR_HI, 5 FIX, 6 MEM, 7 MODIFY, 8 WRITE

Behaviour:
- Reset (rst_i=1 at clock edge):
  - state=FETCH, wait counter=0, running cycle counter=0, cyc_cnt_o=0.
  - All pulses 0; mem_req_o/mem_we_o forced 0 while rst_i high.
- Handshake:
  - mem_req_o=1 in every state except FETCH while halted.
  - A state advances only on the edge where mem_req_o && mem_ready_i ("hs"); otherwise it holds.
  - Outputs are combinational from state and inputs.
- Transitions on hs:
  - FETCH -> OP1. ir_load_o=1 and pc_inc_o=1 during the hs cycle.
  - OP1 (sel PC): pc_inc_o=hs except when mode is IMPLIED (dummy read). IMPLIED/IMMEDIATE -> FETCH; ZP, ZP_X, ZP_Y -> MEM; ABS, ABS_X, ABS_Y -> OP2; IND_X, IND_Y -> PTR_LO.
  - OP2 (sel PC, pc_inc_o=hs): -> FIX if PAGE_PENALTY && page_cross_i && mode in {ABS_X, ABS_Y}, else MEM.
  - PTR_LO (sel ptr) -> PTR_HI. PTR_HI (sel ptr): -> FIX if PAGE_PENALTY && page_cross_i && mode==IND_Y, else MEM.
  - FIX (sel EA, read) -> MEM.
  - MEM (sel EA, mem_we_o = is_store_i && !(is_rmw_i && RMW_EN)): -> MODIFY if RMW_EN && is_rmw_i, else FETCH.
  - MODIFY (sel EA, we=1, dummy write) -> WRITE. WRITE (sel EA, we=1) -> FETCH.
- ZP/ZP_X/ZP_Y select ZP operand (1) in MEM; all other MEM/FIX/MODIFY/WRITE use EA (3).
- Retire: instr_done_o=1 on the hs edge that moves any non-FETCH state to FETCH.
- Cycle counter:
  - Counts every cycle from FETCH entry up to and including the retiring cycle, wait cycles included.
  - On retire, the count (saturated at 2^CYC_W-1) is copied to cyc_cnt_o; then the counter restarts at 0.
- Halt: sampled only in FETCH before hs. While halt_i=1 in FETCH: mem_req_o=0, no pulses, counter held at 0. Halt in any other state has no effect until FETCH.
- Timeout (MAX_WAIT>0):
  - Wait counter increments each cycle with mem_req_o && !mem_ready_i, and clears on hs or on state change.
  - When it would exceed MAX_WAIT: bus_err_o pulses, state -> FETCH, instruction not retired, counters cleared.
  - A hs on the same cycle as the limit wins (no error).
- addr_mode_i changes mid-instruction are honoured only at the decision state; the sequencer latches nothing.
- Reset mid-instruction aborts with no pulses.

Test Plan:
- LDA imm (mode 1), mem_ready_i=1 always -> FETCH, OP1, FETCH; instr_done_o on cycle 2; cyc_cnt_o=2; pc_inc_o 2 times.
- ABS_X load with page_cross_i=1, PAGE_PENALTY=1 -> FETCH, OP1, OP2, FIX, MEM; cyc_cnt_o=5. Same with PAGE_PENALTY=0 -> cyc_cnt_o=4.
- IND_Y store, no cross -> states 0, 1, 3, 4, 6; mem_we_o=1 only in MEM; addr_sel_o sequence 0, 0, 2, 2, 3.
- ZP RMW (mode 2, is_rmw_i=1) -> 0, 1, 6, 7, 8; mem_we_o 0, 0, 0, 1, 1; cyc_cnt_o=5. With RMW_EN=0 -> cyc_cnt_o=3.
- ABS load with mem_ready_i low 3 cycles in OP2 -> state holds 3 cycles; cyc_cnt_o=7. Hold ready low 16 cycles with MAX_WAIT=15 -> bus_err_o pulse, state_o=0, no instr_done_o.
- halt_i=1 in FETCH for 5 cycles -> mem_req_o=0, state 0. Release -> fetch resumes. rst_i during MEM -> next state_o=0, cyc_cnt_o=0.
